room_thermal_model: RTL and testbench

ROOM_THERMAL_MODEL -- requirements
Module: room_thermal_model

---
 rtl/room_pkg.sv | 39 +++
 rtl/room_step_timer.sv | 51 +++++
 rtl/room_thermal_model.sv | 110 +++++++++++
 tb/tb_room_thermal_model.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/room_pkg.sv
// Shared definitions for the room thermal model.
// Holds the temperature width and clamp limits, the step-timer width, the
// mode encoding, and the saturating +/-1 helpers used by the top level.
package room_pkg;

    localparam int TEMP_W   = 5;
    localparam int TEMP_MAX = 31;
    localparam int TEMP_MIN = 0;
    localparam int CNT_W    = 8;

    // Encoding matches the {heating, cooling} command pair directly.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COOL  = 2'b01,
        HEAT  = 2'b10,
        FAULT = 2'b11
    } mode_t;

    // +1 computed one bit wider so the clamp sees the overflow instead of a wrap.
    function automatic logic [TEMP_W-1:0] step_up(input logic [TEMP_W-1:0] t);
        logic [TEMP_W:0] sum;
        sum = {1'b0, t} + (TEMP_W+1)'(1);
        if (sum > (TEMP_W+1)'(TEMP_MAX)) begin
            return TEMP_W'(TEMP_MAX);
        end
        return sum[TEMP_W-1:0];
    endfunction

    // -1 computed one bit wider; the floor is tested before subtracting.
    function automatic logic [TEMP_W-1:0] step_down(input logic [TEMP_W-1:0] t);
        logic [TEMP_W:0] diff;
        if ({1'b0, t} == (TEMP_W+1)'(TEMP_MIN)) begin
            return TEMP_W'(TEMP_MIN);
        end
        diff = {1'b0, t} - (TEMP_W+1)'(1);
        return diff[TEMP_W-1:0];
    endfunction

endpackage

// File: rtl/room_step_timer.sv
// Step timer for the room thermal model.
// Counts rising edges from 0 up to limit-1 and pulses tc on the edge where
// the count wraps back to 0.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset (count -> 0)
//   clear  - force the count to 0 this edge; suppresses tc
//   hold   - freeze the count this edge; suppresses tc
//   limit  - period in edges (2..255)
//   tc     - combinational terminal-count pulse, valid for the coming edge
module room_step_timer
    import room_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             hold,
    input  logic [CNT_W-1:0] limit,
    output logic             tc
);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             at_limit;

    assign at_limit = (count_reg == (limit - CNT_W'(1)));

    always_comb begin
        count_next = count_reg;
        tc         = 1'b0;
        if (clear) begin
            count_next = '0;
        end else if (!hold) begin
            if (at_limit) begin
                count_next = '0;
                tc         = 1'b1;
            end else begin
                count_next = count_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/room_thermal_model.sv
// Room thermal model: a room temperature that rises while heating, falls
// while cooling, drifts toward ambient while idle and freezes when both
// heater and cooler are commanded at once (FAULT).
// Build option: define ROOM_DRIFT_EN to enable idle drift toward ambient;
// without it the idle room simply holds its temperature.
// Parameters: INIT_TEMP (reset temp), STEP_CYCLES (edges per degree when
// heating/cooling), DRIFT_CYCLES (edges per degree of idle drift).
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   heating     - heater command
//   cooling     - cooler command
//   ambient     - outside temperature (degrees)
//   temp        - registered room temperature (degrees)
//   fault       - registered, high while in FAULT
//   fault_seen  - sticky, set on any FAULT entry until reset
module room_thermal_model
    import room_pkg::*;
#(
    parameter int INIT_TEMP    = 20,
    parameter int STEP_CYCLES  = 4,
    parameter int DRIFT_CYCLES = 16
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              heating,
    input  logic              cooling,
    input  logic [TEMP_W-1:0] ambient,
    output logic [TEMP_W-1:0] temp,
    output logic              fault,
    output logic              fault_seen
);

    mode_t             mode_reg;
    mode_t             mode_next;
    logic [TEMP_W-1:0] temp_reg;
    logic [TEMP_W-1:0] temp_next;
    logic              fault_reg;
    logic              fault_next;
    logic              fault_seen_reg;
    logic              fault_seen_next;

    logic              mode_change;
    logic              idle_still;
    logic              timer_clear;
    logic              timer_hold;
    logic              tc;
    logic [CNT_W-1:0]  limit;

    assign mode_next   = mode_t'({heating, cooling});
    assign mode_change = (mode_next != mode_reg);

`ifdef ROOM_DRIFT_EN
    assign idle_still = (temp_reg == ambient);
`else
    // Drift disabled: idle always holds. The OR keeps ambient referenced
    // so the port stays part of the design without affecting behaviour.
    assign idle_still = (temp_reg == ambient) | 1'b1;
`endif

    assign limit = (mode_reg == IDLE) ? CNT_W'(DRIFT_CYCLES) : CNT_W'(STEP_CYCLES);

    // A mode change clears the timer, which also suppresses tc, so a
    // coincident terminal count never updates temp on a switch edge.
    assign timer_clear = mode_change | ((mode_reg == IDLE) & idle_still);
    assign timer_hold  = (mode_reg == FAULT);

    room_step_timer u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (timer_clear),
        .hold  (timer_hold),
        .limit (limit),
        .tc    (tc)
    );

    always_comb begin
        temp_next       = temp_reg;
        fault_next      = (mode_next == FAULT);
        fault_seen_next = fault_seen_reg | (mode_change & (mode_next == FAULT));
        if (tc) begin
            case (mode_reg)
                HEAT:    temp_next = step_up(temp_reg);
                COOL:    temp_next = step_down(temp_reg);
                IDLE:    temp_next = (temp_reg < ambient) ? step_up(temp_reg)
                                                          : step_down(temp_reg);
                default: temp_next = temp_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_reg       <= IDLE;
            temp_reg       <= TEMP_W'(INIT_TEMP);
            fault_reg      <= 1'b0;
            fault_seen_reg <= 1'b0;
        end else begin
            mode_reg       <= mode_next;
            temp_reg       <= temp_next;
            fault_reg      <= fault_next;
            fault_seen_reg <= fault_seen_next;
        end
    end

    assign temp       = temp_reg;
    assign fault      = fault_reg;
    assign fault_seen = fault_seen_reg;

endmodule

// File: tb/tb_room_thermal_model.sv
// Testbench for room_thermal_model with directed scenarios. Expected
// outputs come from an elapsed-time model of the room (edges since the last
// counting origin) plus hand-computed literal checkpoints.
module tb_room_thermal_model;

    localparam int STEP  = 4;
    localparam int DRIFT = 16;
    localparam int INIT  = 20;

    logic       clk;
    logic       rst_n;
    logic       heating;
    logic       cooling;
    logic [4:0] ambient;
    logic [4:0] temp;
    logic       fault;
    logic       fault_seen;
    logic [1:0] cmd;

    int tests = 0;
    int fails = 0;

    room_thermal_model #(
        .INIT_TEMP    (INIT),
        .STEP_CYCLES  (STEP),
        .DRIFT_CYCLES (DRIFT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .heating    (heating),
        .cooling    (cooling),
        .ambient    (ambient),
        .temp       (temp),
        .fault      (fault),
        .fault_seen (fault_seen)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign cmd = {heating, cooling};

    // ---------------- behavioural model ----------------
    // Mode codes: 0 idle, 1 cool, 2 heat, 3 fault.
    // The room changes whenever a whole number of periods has elapsed since
    // the anchor edge; the anchor moves on mode entry, slides forward while
    // frozen in fault, and sticks to "now" while idle at equilibrium.
    int m_mode;
    int m_temp;
    int m_n;
    int m_anchor;
    bit m_fault_seen;

    function automatic int next_temp(int mode, int t, int amb);
        case (mode)
            2:       return (t < 31) ? t + 1 : 31;
            1:       return (t > 0) ? t - 1 : 0;
            0:       return (t < amb) ? t + 1 : ((t > amb) ? t - 1 : t);
            default: return t;
        endcase
    endfunction

    function automatic bit at_rest(int t, int amb);
`ifdef ROOM_DRIFT_EN
        return t == amb;
`else
        return (t == amb) || 1'b1;
`endif
    endfunction

    function automatic int period(int mode);
        return (mode == 0) ? DRIFT : STEP;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode       <= 0;
            m_temp       <= INIT;
            m_n          <= 0;
            m_anchor     <= 0;
            m_fault_seen <= 1'b0;
        end else begin
            m_n <= m_n + 1;
            if (int'(cmd) != m_mode) begin
                m_mode   <= int'(cmd);
                m_anchor <= m_n + 1;
                if (cmd == 2'b11) m_fault_seen <= 1'b1;
            end else if (m_mode == 3) begin
                m_anchor <= m_anchor + 1;
            end else if (m_mode == 0 && at_rest(m_temp, int'(ambient))) begin
                m_anchor <= m_n + 1;
            end else if (((m_n + 1 - m_anchor) % period(m_mode)) == 0) begin
                m_temp <= next_temp(m_mode, m_temp, int'(ambient));
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic compare_all();
        check("temp", int'(temp), m_temp);
        check("fault", int'(fault), (m_mode == 3) ? 1 : 0);
        check("fault_seen", int'(fault_seen), int'(m_fault_seen));
    endtask

    // Advance k falling edges, comparing against the model on each one.
    task automatic tick(input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            compare_all();
        end
    endtask

    task automatic do_reset();
        heating = 1'b0;
        cooling = 1'b0;
        rst_n   = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic set_cmd(input logic h, input logic c);
        heating = h;
        cooling = c;
    endtask

    initial begin
        rst_n   = 1'b0;
        heating = 1'b0;
        cooling = 1'b0;
        ambient = 5'd20;

        // Reset and idle at ambient
        tick(3);
        rst_n = 1'b1;
        check("lit_reset_temp", int'(temp), 20);
        check("lit_reset_fault", int'(fault), 0);
        check("lit_reset_fault_seen", int'(fault_seen), 0);
        tick(50);
        check("lit_idle50_temp", int'(temp), 20);
        $display("[TB] idle at ambient: temp=%0d", temp);

        // Heating from 20
        set_cmd(1'b1, 1'b0);
        tick(4);
        check("lit_heat_e3", int'(temp), 20);
        tick(1);
        check("lit_heat_e4", int'(temp), 21);
        tick(12);
        check("lit_heat_e16", int'(temp), 24);
        tick(40);
        check("lit_heat_sat", int'(temp), 31);
        tick(8);
        check("lit_heat_sat_hold", int'(temp), 31);
        $display("[TB] heating: temp=%0d", temp);

        // Cooling from 31, then a 3-edge heat blip before cooling again
        set_cmd(1'b0, 1'b1);
        tick(4);
        check("lit_cool_e3", int'(temp), 31);
        tick(1);
        check("lit_cool_e4", int'(temp), 30);
        tick(8);
        check("lit_cool_e12", int'(temp), 28);
        set_cmd(1'b1, 1'b0);
        tick(3);
        check("lit_blip_heat", int'(temp), 28);
        set_cmd(1'b0, 1'b1);
        tick(4);
        check("lit_recool_e3", int'(temp), 28);
        tick(1);
        check("lit_recool_e4", int'(temp), 27);
        $display("[TB] cool after heat blip: temp=%0d", temp);

        // Cooling from 20 down to 0
        do_reset();
        set_cmd(1'b0, 1'b1);
        tick(80);
        check("lit_cool_e79", int'(temp), 1);
        tick(1);
        check("lit_cool_e80", int'(temp), 0);
        tick(20);
        check("lit_cool_floor", int'(temp), 0);
        $display("[TB] cool to floor: temp=%0d", temp);

        // Fault: both commands for 3 edges from 22
        do_reset();
        set_cmd(1'b1, 1'b0);
        tick(9);
        check("lit_pre_fault_temp", int'(temp), 22);
        set_cmd(1'b1, 1'b1);
        tick(1);
        check("lit_fault_on", int'(fault), 1);
        check("lit_fault_seen_on", int'(fault_seen), 1);
        tick(2);
        check("lit_fault_temp", int'(temp), 22);
        set_cmd(1'b0, 1'b0);
        tick(1);
        check("lit_fault_off", int'(fault), 0);
        check("lit_fault_seen_sticky", int'(fault_seen), 1);
        check("lit_fault_release_temp", int'(temp), 22);
        tick(20);
        check("lit_fault_seen_later", int'(fault_seen), 1);
        $display("[TB] fault pulse: fault=%0d fault_seen=%0d temp=%0d", fault, fault_seen, temp);

        // Idle drift toward a warmer ambient (idle entered via a mode switch)
        do_reset();
        set_cmd(1'b0, 1'b1);
        tick(1);
        set_cmd(1'b0, 1'b0);
        ambient = 5'd24;
        tick(16);
        check("lit_drift_e15", int'(temp), 20);
        tick(1);
`ifdef ROOM_DRIFT_EN
        check("lit_drift_e16", int'(temp), 21);
`else
        check("lit_drift_e16", int'(temp), 20);
`endif
        tick(48);
`ifdef ROOM_DRIFT_EN
        check("lit_drift_e64", int'(temp), 24);
`else
        check("lit_drift_e64", int'(temp), 20);
`endif
        tick(20);
`ifdef ROOM_DRIFT_EN
        check("lit_drift_hold", int'(temp), 24);
`else
        check("lit_drift_hold", int'(temp), 20);
`endif
        $display("[TB] idle drift: ambient=%0d temp=%0d", ambient, temp);

        // Asynchronous reset in the middle of heating
        ambient = 5'd20;
        do_reset();
        set_cmd(1'b1, 1'b0);
        tick(25);
        check("lit_heat_26", int'(temp), 26);
        #2;
        rst_n = 1'b0;
        #1;
        check("lit_async_rst_temp", int'(temp), 20);
        check("lit_async_rst_fault", int'(fault), 0);
        check("lit_async_rst_fault_seen", int'(fault_seen), 0);
        tick(1);
        rst_n = 1'b1;
        tick(4);
        check("lit_post_rst_e3", int'(temp), 20);
        tick(1);
        check("lit_post_rst_e4", int'(temp), 21);
        $display("[TB] async reset mid-heat: temp=%0d", temp);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
